exception_unit: RTL and testbench

Parametrised exception/interrupt controller for the multicycle MIPS core. It replaces the fixed two-cause EPC/Cause/vector-byte logic with NUM_SRC prioritised, maskable sources. It latches pending requests, handshakes with the control unit at an instruction boundary, captures EPC and Cause, and fetches the handler address from a word vector table in memory. It then drives the PC load and handles return-from-exception (rfe). The block sits between the control unit, the memory address/data path and the PC mux.

---
 rtl/exc_pkg.sv | 20 ++
 rtl/exc_prio_enc.sv | 23 ++
 rtl/exception_unit.sv | 134 +++++++++++++
 tb/tb_exception_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared FSM state type and constants for the exception unit
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    LOAD  = 3'd4,
    RET   = 3'd5
  } exc_state_t;

  // Cause codes of the original core's fixed sources
  localparam int EXC_OVF    = 0;
  localparam int EXC_OPCODE = 1;

  // Byte address of vector table entry 0
  localparam int VEC_BASE_DEFAULT = 252;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - lowest-index-wins priority encoder
module exc_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top so the lowest set index is the last (winning) assignment
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - prioritised maskable trap controller with vector table fetch
module exception_unit
  import exc_pkg::*;
#(
  parameter int                NUM_SRC         = 4,
  parameter int                CAUSE_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE        = ADDR_W'(VEC_BASE_DEFAULT),
  parameter logic [ADDR_W-1:0] DEFAULT_HANDLER = ADDR_W'(32'h0000_0100)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] exc_req,
  input  logic [NUM_SRC-1:0] exc_en,
  input  logic [ADDR_W-1:0]  epc_in,
  input  logic               trap_ack,
  input  logic               rfe,
  input  logic [ADDR_W-1:0]  mem_rdata,
  output logic               trap_req,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_value,
  output logic [CAUSE_W-1:0] cause,
  output logic [ADDR_W-1:0]  epc,
  output logic               in_handler,
  output logic               busy
);

  exc_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [ADDR_W-1:0]  epc_q, epc_d;
  logic [ADDR_W-1:0]  vec_q, vec_d;
  logic               in_handler_q, in_handler_d;

  logic [CAUSE_W-1:0] sel_idx;
  logic               sel_valid;

  exc_prio_enc #(
    .N  (NUM_SRC),
    .IW (CAUSE_W)
  ) u_prio (
    .req   (pending_q),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  // Next-state: pending latch, trap handshake, vector fetch and return sequencing
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | (exc_req & exc_en);
    cause_d      = cause_q;
    epc_d        = epc_q;
    vec_d        = vec_q;
    in_handler_d = in_handler_q;
    case (state_q)
      IDLE: begin
        // A return takes precedence; traps wait while a handler is active
        if (rfe && in_handler_q) begin
          state_d = RET;
        end else if (sel_valid && !in_handler_q) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (trap_ack) begin
          epc_d     = epc_in;
          cause_d   = sel_idx;
          pending_d = (pending_q & ~(NUM_SRC'(1) << sel_idx)) | (exc_req & exc_en);
          state_d   = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        vec_d   = mem_rdata;
        state_d = LOAD;
      end
      LOAD: begin
        in_handler_d = 1'b1;
        state_d      = IDLE;
      end
      RET: begin
        // Anything that queued up during the handler is requested right away
        in_handler_d = 1'b0;
        state_d      = sel_valid ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      cause_q      <= '0;
      epc_q        <= '0;
      vec_q        <= '0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      vec_q        <= vec_d;
      in_handler_q <= in_handler_d;
    end
  end

  // Outputs decoded from state and registered values only
  always_comb begin
    trap_req   = (state_q == REQ);
    mem_rd     = (state_q == FETCH);
    mem_addr   = '0;
    pc_load    = 1'b0;
    pc_value   = '0;
    cause      = cause_q;
    epc        = epc_q;
    in_handler = in_handler_q;
    busy       = (state_q != IDLE);
    if (state_q == FETCH) begin
      mem_addr = VEC_BASE + (ADDR_W'(cause_q) << 2);
    end
    if (state_q == LOAD) begin
      pc_load  = 1'b1;
      pc_value = (vec_q == '0) ? DEFAULT_HANDLER : vec_q;
    end else if (state_q == RET) begin
      pc_load  = 1'b1;
      pc_value = epc_q;
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// tb/tb_exception_unit.sv - scoreboard bench for exception_unit
module tb_exception_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  exc_req;
  logic [3:0]  exc_en;
  logic [31:0] epc_in;
  logic        trap_ack;
  logic        rfe;
  logic [31:0] mem_rdata;
  logic        trap_req;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        pc_load;
  logic [31:0] pc_value;
  logic [1:0]  cause;
  logic [31:0] epc;
  logic        in_handler;
  logic        busy;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  cause;
    logic [31:0] epc;
  } exp_pc_t;

  logic [31:0] exp_addr_q[$];
  exp_pc_t     exp_pc_q[$];

  int checks   = 0;
  int failures = 0;

  exception_unit dut (
    .clock      (clock),
    .reset      (reset),
    .exc_req    (exc_req),
    .exc_en     (exc_en),
    .epc_in     (epc_in),
    .trap_ack   (trap_ack),
    .rfe        (rfe),
    .mem_rdata  (mem_rdata),
    .trap_req   (trap_req),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .pc_load    (pc_load),
    .pc_value   (pc_value),
    .cause      (cause),
    .epc        (epc),
    .in_handler (in_handler),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_trap_req"}, 32'(trap_req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_pc_load"}, 32'(pc_load), 0);
    chk({tag, "_pc_value"}, pc_value, 0);
    chk({tag, "_cause"}, 32'(cause), 0);
    chk({tag, "_epc"}, epc, 0);
    chk({tag, "_in_handler"}, 32'(in_handler), 0);
  endtask

  task automatic pulse_req(input logic [3:0] v);
    exc_req = v;
    tick(1);
    exc_req = 4'b0;
  endtask

  task automatic wait_trap_req();
    int n = 0;
    while (!trap_req && n < 20) begin
      tick(1);
      n++;
    end
    chk("trap_req_wait", 32'(trap_req), 1);
  endtask

  // Full trap handshake; expected fetch address and PC load go to the scoreboard
  task automatic do_trap(input int idx, input logic [31:0] epcv, input logic [31:0] vecv);
    exp_pc_t e;
    exp_addr_q.push_back(32'(252 + 4 * idx));
    e.pc    = (vecv == 0) ? 32'h100 : vecv;
    e.cause = 2'(idx);
    e.epc   = epcv;
    exp_pc_q.push_back(e);
    mem_rdata = vecv;
    epc_in    = epcv;
    wait_trap_req();
    tick(1);
    trap_ack = 1'b1;
    tick(1);
    trap_ack = 1'b0;
    tick(3);
    chk("in_handler_set", 32'(in_handler), 1);
    chk("busy_after_load", 32'(busy), 0);
  endtask

  task automatic do_rfe(input logic [31:0] epcv, input int idx);
    exp_pc_t e;
    e.pc    = epcv;
    e.cause = 2'(idx);
    e.epc   = epcv;
    exp_pc_q.push_back(e);
    rfe = 1'b1;
    tick(1);
    rfe = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a fetch or PC load
  always @(negedge clock) begin
    if (mem_rd) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_mem_rd", 32'(mem_rd), 0);
      end else begin
        chk("mem_addr", mem_addr, exp_addr_q.pop_front());
      end
    end
    if (pc_load) begin
      if (exp_pc_q.size() == 0) begin
        chk("unexpected_pc_load", 32'(pc_load), 0);
      end else begin
        exp_pc_t e;
        e = exp_pc_q.pop_front();
        chk("pc_value", pc_value, e.pc);
        chk("cause", 32'(cause), 32'(e.cause));
        chk("epc", epc, e.epc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; exc_req = '0; exc_en = '0; epc_in = '0;
    trap_ack = 1'b0; rfe = 1'b0; mem_rdata = '0;
    tick(2);
    check_all_zero("reset");
    reset = 1'b1;
    tick(1);

    // Single trap with exact request latency
    exc_en  = 4'b1111;
    exc_req = 4'b0010;
    tick(1);
    exc_req = 4'b0;
    chk("lat_idle", 32'(trap_req), 0);
    tick(1);
    chk("lat_req", 32'(trap_req), 1);
    do_trap(1, 32'h40, 32'h300);
    chk("single_cause", 32'(cause), 1);
    chk("single_epc", epc, 32'h40);
    do_rfe(32'h40, 1);
    tick(1);
    chk("rfe_clears_handler", 32'(in_handler), 0);
    tick(2);

    // Priority: 1 before 3, 3 requested right after the return
    pulse_req(4'b1010);
    do_trap(1, 32'h80, 32'h400);
    do_rfe(32'h80, 1);
    tick(1);
    chk("prio_second_req", 32'(trap_req), 1);
    do_trap(3, 32'h90, 32'h500);
    do_rfe(32'h90, 3);
    tick(2);

    // Mask: disabled sources never latch
    exc_en  = 4'b0;
    exc_req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("mask_trap_req", 32'(trap_req), 0);
      chk("mask_busy", 32'(busy), 0);
    end
    exc_req = 4'b0;
    exc_en  = 4'b1111;
    tick(3);
    chk("mask_no_late_trap", 32'(busy), 0);

    // Default vector, then nesting held off until return
    pulse_req(4'b0100);
    do_trap(2, 32'h44, 32'h0);
    pulse_req(4'b0001);
    tick(3);
    chk("nest_held", 32'(trap_req), 0);
    do_rfe(32'h44, 2);
    tick(1);
    chk("nest_req_after_ret", 32'(trap_req), 1);
    do_trap(0, 32'h60, 32'h700);
    chk("nest_epc_updated", epc, 32'h60);
    chk("nest_cause", 32'(cause), 0);
    do_rfe(32'h60, 0);
    tick(2);

    // Reset during WAIT with a second source still pending
    exp_addr_q.push_back(32'd252);
    mem_rdata = 32'h900;
    epc_in    = 32'h70;
    pulse_req(4'b0011);
    wait_trap_req();
    tick(1);
    trap_ack = 1'b1;
    tick(1);
    trap_ack = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    check_all_zero("midfetch");
    reset = 1'b1;
    tick(5);
    chk("midfetch_pending_cleared", 32'(busy), 0);
    chk("midfetch_no_req", 32'(trap_req), 0);

    chk("addr_q_drained", 32'(exp_addr_q.size()), 0);
    chk("pc_q_drained", 32'(exp_pc_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
